bus_master_bridge: RTL and testbench

- Single bus master that drives the `bus_in` bundle consumed by all register slaves.
- Collects their OR-combined `bus_out` bundle.
- Converts a host-side valid/ready command stream (from the UART/USB command decoder) into one-cycle `bus_rd_req`/`bus_wr_req` pulses.
- Waits for the matching registered ack, or times out on unmapped addresses, and returns a response with read data and an error flag.

---
 rtl/bus_master_bridge.sv | 150 +++++++++++++++
 tb/tb_bus_master_bridge.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_bridge.sv
// bus_master_bridge: single master of the register bus.
// Turns a host valid/ready command stream into one-cycle rd/wr request pulses
// on the bus_in bundle. It waits for the matching registered ack from the
// OR-combined bus_out bundle, or times out on unmapped addresses, then returns
// one response carrying read data and an error flag.
// Bundle field positions are parameters. Their defaults describe the shared
// bus layout, so slaves and master agree on it.
module bus_master_bridge #(
  parameter int unsigned TIMEOUT           = 64,
  parameter int unsigned BUS_ADDR_WIDTH    = 16,
  parameter int unsigned BUS_DATA_WIDTH    = 32,
  // bus_in layout (master -> slaves)
  parameter int unsigned BUS_FIELD_CLK     = 0,
  parameter int unsigned BUS_FIELD_RESET_L = 1,
  parameter int unsigned BUS_FIELD_RD_REQ  = 2,
  parameter int unsigned BUS_FIELD_WR_REQ  = 3,
  parameter int unsigned BUS_FIELD_ADDR    = 4,
  parameter int unsigned BUS_FIELD_WR_DATA = BUS_FIELD_ADDR + BUS_ADDR_WIDTH,
  parameter int unsigned BUS_IN_WIDTH      = BUS_FIELD_WR_DATA + BUS_DATA_WIDTH,
  // bus_out layout (OR of all slaves -> master)
  parameter int unsigned BUS_FIELD_RD_ACK  = 0,
  parameter int unsigned BUS_FIELD_WR_ACK  = 1,
  parameter int unsigned BUS_FIELD_IRQ     = 2,
  parameter int unsigned BUS_FIELD_RD_DATA = 3,
  parameter int unsigned BUS_OUT_WIDTH     = BUS_FIELD_RD_DATA + BUS_DATA_WIDTH
) (
  input  logic                      bus_clk,
  input  logic                      bus_reset_l,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_wr,
  input  logic [BUS_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [BUS_DATA_WIDTH-1:0] cmd_wr_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [BUS_DATA_WIDTH-1:0] rsp_rd_data,
  output logic                      rsp_err,
  output logic                      irq,
  output logic [BUS_IN_WIDTH-1:0]   bus_in,
  input  logic [BUS_OUT_WIDTH-1:0]  bus_out
);

  // Last WAIT index before giving up; the counter never goes past it.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                    state_reg;
  logic                      is_wr_reg;
  logic                      bus_rd_req_reg;
  logic                      bus_wr_req_reg;
  logic [BUS_ADDR_WIDTH-1:0] bus_addr_reg;
  logic [BUS_DATA_WIDTH-1:0] bus_wr_data_reg;
  logic                      rsp_valid_reg;
  logic                      rsp_err_reg;
  logic [BUS_DATA_WIDTH-1:0] rsp_rd_data_reg;
  logic                      irq_reg;
  logic [15:0]               wait_cnt_reg;
  logic                      ack_match;

  // Only the ack that matches the outstanding direction completes a transaction.
  assign ack_match = is_wr_reg ? bus_out[BUS_FIELD_WR_ACK] : bus_out[BUS_FIELD_RD_ACK];

  assign cmd_ready   = (state_reg == ST_IDLE);
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_rd_data = rsp_rd_data_reg;
  assign irq         = irq_reg;

  // Build the bus_in bundle; clock and reset pass straight through unregistered.
  always_comb begin
    bus_in                                        = '0;
    bus_in[BUS_FIELD_CLK]                         = bus_clk;
    bus_in[BUS_FIELD_RESET_L]                     = bus_reset_l;
    bus_in[BUS_FIELD_RD_REQ]                      = bus_rd_req_reg;
    bus_in[BUS_FIELD_WR_REQ]                      = bus_wr_req_reg;
    bus_in[BUS_FIELD_ADDR +: BUS_ADDR_WIDTH]      = bus_addr_reg;
    bus_in[BUS_FIELD_WR_DATA +: BUS_DATA_WIDTH]   = bus_wr_data_reg;
  end

  // Transaction FSM: every bus and response output is a register updated here.
  always_ff @(posedge bus_clk) begin
    if (!bus_reset_l) begin
      state_reg       <= ST_IDLE;
      is_wr_reg       <= 1'b0;
      bus_rd_req_reg  <= 1'b0;
      bus_wr_req_reg  <= 1'b0;
      bus_addr_reg    <= '0;
      bus_wr_data_reg <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_err_reg     <= 1'b0;
      rsp_rd_data_reg <= '0;
      irq_reg         <= 1'b0;
      wait_cnt_reg    <= '0;
    end else begin
      irq_reg <= bus_out[BUS_FIELD_IRQ];
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            bus_addr_reg    <= cmd_addr;
            bus_wr_data_reg <= cmd_wr ? cmd_wr_data : '0;
            is_wr_reg       <= cmd_wr;
            // Request pulses rise here so they are high for the whole REQ cycle.
            bus_wr_req_reg  <= cmd_wr;
            bus_rd_req_reg  <= !cmd_wr;
            state_reg       <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Acks during REQ cannot belong to this request (slaves register them).
          bus_wr_req_reg <= 1'b0;
          bus_rd_req_reg <= 1'b0;
          wait_cnt_reg   <= '0;
          state_reg      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ack_match) begin
            // Ack beats a coincident timeout.
            rsp_rd_data_reg <= is_wr_reg ? '0 : bus_out[BUS_FIELD_RD_DATA +: BUS_DATA_WIDTH];
            rsp_err_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= ST_RESP;
          end else if (wait_cnt_reg == TIMEOUT_LAST) begin
            rsp_rd_data_reg <= '0;
            rsp_err_reg     <= 1'b1;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= ST_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg   <= 1'b0;
            bus_addr_reg    <= '0;
            bus_wr_data_reg <= '0;
            state_reg       <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_bridge.sv
// Directed bench for bus_master_bridge: a registered-ack slave at 0x10 plus
// injectable ack/data/irq bits on bus_out, and hand-computed expected values.
module tb_bus_master_bridge;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int IN_W  = 4 + AW + DW;
  localparam int OUT_W = 3 + DW;
  localparam logic [AW-1:0] SLAVE_ADDR = 16'h0010;

  logic          bus_clk = 1'b0;
  logic          bus_reset_l;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wr_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rd_data;
  logic          rsp_err;
  logic          irq;
  logic [IN_W-1:0]  bus_in;
  logic [OUT_W-1:0] bus_out;

  // Injected bus_out contributions
  logic          inj_rd_ack, inj_wr_ack, inj_irq;
  logic [DW-1:0] inj_data;

  // Slave model state
  logic          s_rd_ack, s_wr_ack;
  logic [DW-1:0] s_data;
  logic [DW-1:0] slave_in;
  logic [DW-1:0] slave_reg;
  int            wr_pulses = 0;

  int checks   = 0;
  int failures = 0;

  // Decoded bus_in fields
  logic          t_rd_req, t_wr_req;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wr_data;
  assign t_rd_req  = bus_in[2];
  assign t_wr_req  = bus_in[3];
  assign t_addr    = bus_in[4 +: AW];
  assign t_wr_data = bus_in[4 + AW +: DW];

  assign bus_out = {s_data | inj_data, inj_irq, s_wr_ack | inj_wr_ack, s_rd_ack | inj_rd_ack};

  bus_master_bridge dut (
    .bus_clk     (bus_clk),
    .bus_reset_l (bus_reset_l),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wr_data (cmd_wr_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rd_data (rsp_rd_data),
    .rsp_err     (rsp_err),
    .irq         (irq),
    .bus_in      (bus_in),
    .bus_out     (bus_out)
  );

  always #5 bus_clk = ~bus_clk;

  // Registered-ack register slave at SLAVE_ADDR.
  always @(posedge bus_clk) begin
    if (!bus_reset_l) begin
      s_rd_ack  <= 1'b0;
      s_wr_ack  <= 1'b0;
      s_data    <= '0;
      slave_reg <= '0;
    end else begin
      s_rd_ack <= t_rd_req && (t_addr == SLAVE_ADDR);
      s_wr_ack <= t_wr_req && (t_addr == SLAVE_ADDR);
      s_data   <= (t_rd_req && (t_addr == SLAVE_ADDR)) ? slave_in : '0;
      if (t_wr_req && (t_addr == SLAVE_ADDR)) begin
        wr_pulses <= wr_pulses + 1;
        slave_reg <= t_wr_data;
      end
    end
  end

  task automatic step();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Safety net in case the run is somehow stuck.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    bus_reset_l = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wr_data = '0;
    rsp_ready = 1'b0; inj_rd_ack = 1'b0; inj_wr_ack = 1'b0; inj_irq = 1'b0; inj_data = '0;
    slave_in = 32'h12345678;

    // ---- Reset state ----
    step(); step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_rd_data, 0);
    chk("rst_irq", irq, 0);
    chk("rst_reqs", {t_rd_req, t_wr_req}, 0);
    chk("rst_addr", t_addr, 0);
    chk("rst_wdata", t_wr_data, 0);
    chk("rst_fwd_reset_l", bus_in[1], 0);
    chk("fwd_clk", bus_in[0], 1);
    bus_reset_l = 1'b1;
    step();
    chk("fwd_reset_l_high", bus_in[1], 1);
    $display("txn reset done");

    // ---- Write 0xDEADBEEF to 0x10, with noise on the read-data field ----
    inj_data = 32'hA5A5A5A5;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0010; cmd_wr_data = 32'hDEADBEEF;
    step();                                   // accept edge E0
    cmd_valid = 1'b0;
    chk("wr_req_high", {t_wr_req, t_rd_req}, 2'b10);
    chk("wr_addr", t_addr, 16'h0010);
    chk("wr_data_bus", t_wr_data, 32'hDEADBEEF);
    chk("wr_cmd_ready_busy", cmd_ready, 0);
    step();                                   // E1
    chk("wr_req_one_cycle", {t_wr_req, t_rd_req}, 0);
    chk("wr_rsp_not_yet", rsp_valid, 0);
    step();                                   // E2
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_data_zero", rsp_rd_data, 0);
    chk("wr_pulse_once", wr_pulses, 1);
    chk("wr_slave_reg", slave_reg, 32'hDEADBEEF);
    chk("wr_hold_addr", t_addr, 16'h0010);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wr_consumed", {rsp_valid, cmd_ready}, 2'b01);
    chk("wr_addr_cleared", t_addr, 0);
    chk("wr_wdata_cleared", t_wr_data, 0);
    inj_data = '0;
    $display("txn write 0x10 <= 0xdeadbeef rsp_err=%0d", rsp_err);

    // ---- Read 0x10 ----
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0010; cmd_wr_data = 32'hCAFEF00D;
    step();
    cmd_valid = 1'b0;
    chk("rd_req_high", {t_rd_req, t_wr_req}, 2'b10);
    chk("rd_wdata_zero", t_wr_data, 0);
    step();
    chk("rd_req_one_cycle", t_rd_req, 0);
    step();
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_rd_data, 32'h12345678);
    chk("rd_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    $display("txn read 0x10 => 0x%0h", rsp_rd_data);

    // ---- Read unmapped 0x3F0: timeout after 64 WAIT cycles ----
    inj_data = 32'h00000055;                  // noise that must not leak on error
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h03F0;
    step();                                   // E0
    cmd_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 64; i++) begin        // E1..E64
      step();
      if (rsp_valid) bad = 1'b1;
    end
    chk("to_no_early_rsp", bad, 0);
    step();                                   // E65
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data_zero", rsp_rd_data, 0);
    inj_data = '0;
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    inj_rd_ack = 1'b1; inj_data = 32'h99999999;
    step();
    inj_rd_ack = 1'b0; inj_data = '0;
    step();
    chk("late_ack_no_rsp", rsp_valid, 0);
    chk("late_ack_cmd_ready", cmd_ready, 1);
    chk("late_ack_data_kept", rsp_rd_data, 0);
    $display("txn read 0x3f0 => timeout err=1");

    // ---- Backpressure: rsp_ready low for 10 cycles, cmd_valid held high ----
    slave_in = 32'h0BADF00D;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0010;
    step(); step(); step();                   // accept, REQ, WAIT -> RESP
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_data", rsp_rd_data, 32'h0BADF00D);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'h0BADF00D || cmd_ready !== 1'b0 ||
          t_rd_req !== 1'b0) bad = 1'b1;
    end
    chk("bp_stable_10", bad, 0);
    rsp_ready = 1'b1;
    step();                                   // handshake edge
    rsp_ready = 1'b0;
    chk("bp_after_hs", {cmd_ready, rsp_valid, t_rd_req}, 3'b100);
    step();                                   // held cmd_valid accepted here
    cmd_valid = 1'b0;
    chk("bp_second_accept", {t_rd_req, cmd_ready}, 2'b10);
    step(); step();
    chk("bp_second_rsp", rsp_rd_data, 32'h0BADF00D);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    $display("txn backpressure read 0x10 => 0x%0h", rsp_rd_data);

    // ---- Reset in the middle of WAIT ----
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h03F0;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();                   // into WAIT
    bus_reset_l = 1'b0;
    step();
    bus_reset_l = 1'b1;
    chk("mid_rst_idle", {cmd_ready, rsp_valid, t_rd_req, t_wr_req}, 4'b1000);
    chk("mid_rst_addr", t_addr, 0);
    chk("mid_rst_err", rsp_err, 0);
    bad = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (rsp_valid) bad = 1'b1;
    end
    chk("mid_rst_no_rsp", bad, 0);
    slave_in = 32'h13579BDF;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0010;
    step();
    cmd_valid = 1'b0;
    step(); step();
    chk("post_rst_read", {rsp_valid, rsp_err, rsp_rd_data}, {2'b10, 32'h13579BDF});
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    $display("txn reset-in-wait then read 0x10 => 0x%0h", rsp_rd_data);

    // ---- Timeout boundary: ack on WAIT index 63; stray acks ignored ----
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h03F0;
    step();                                   // E0, now in REQ
    cmd_valid = 1'b0;
    inj_rd_ack = 1'b1; inj_data = 32'h11111111;   // ack during REQ: ignored
    step();                                   // E1, WAIT idx 0
    inj_rd_ack = 1'b0; inj_data = '0;
    inj_wr_ack = 1'b1;                        // wrong-direction ack: ignored
    step();                                   // E2
    inj_wr_ack = 1'b0;
    chk("stray_ack_ignored", rsp_valid, 0);
    for (int i = 0; i < 62; i++) step();      // E64, WAIT idx 63
    chk("bnd_not_yet", rsp_valid, 0);
    inj_rd_ack = 1'b1; inj_data = 32'h600DCAFE;
    step();                                   // E65
    inj_rd_ack = 1'b0; inj_data = '0;
    chk("bnd_rsp_valid", rsp_valid, 1);
    chk("bnd_rsp_err", rsp_err, 0);
    chk("bnd_rsp_data", rsp_rd_data, 32'h600DCAFE);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    $display("txn boundary-ack read 0x3f0 => 0x%0h err=%0d", rsp_rd_data, rsp_err);

    // ---- irq follows bus_out irq one cycle later ----
    inj_irq = 1'b1;
    #1;
    chk("irq_not_yet", irq, 0);
    step();
    chk("irq_rise", irq, 1);
    inj_irq = 1'b0;
    step();
    chk("irq_fall", irq, 0);
    $display("txn irq toggle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
